present_ctrl: RTL and testbench

Iterative PRESENT-80 encryption sequencer. It owns the 64-bit cipher state, the 80-bit key register and the round counter, and drives the round datapath (addRoundKey, sBoxLayer, pLayer and key update) one round per clock for 31 rounds, then applies final key whitening. It sits between a requester, which uses a start/ready/done handshake, and the permutation and S-box datapath.

---
 rtl/present_pkg.sv | 49 ++++
 rtl/present_round.sv | 29 ++
 rtl/present_ctrl.sv | 98 +++++++++
 tb/tb_present_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/present_pkg.sv
// Shared PRESENT-80 definitions: FSM encoding, widths, S-box and pLayer helpers.
package present_pkg;

  localparam int BLOCK_W = 64;
  localparam int KEY_W   = 80;
  localparam int ROUND_W = 5;
  localparam logic [ROUND_W-1:0] ROUNDS = 5'd31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FINAL = 2'd2
  } fsm_t;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  // Bit i moves to position 16*i mod 63; bit 63 stays put.
  function automatic logic [BLOCK_W-1:0] p_layer(input logic [BLOCK_W-1:0] x);
    logic [BLOCK_W-1:0] y;
    y = '0;
    y[63] = x[63];
    for (int i = 0; i < 63; i++) begin
      y[6'((16 * i) % 63)] = x[6'(i)];
    end
    return y;
  endfunction

endpackage

// File: rtl/present_round.sv
// Combinational PRESENT-80 round: addRoundKey, sBoxLayer, pLayer and key schedule step.
module present_round
  import present_pkg::*;
(
  input  logic [BLOCK_W-1:0] state,
  input  logic [KEY_W-1:0]   keyreg,
  input  logic [ROUND_W-1:0] round,
  output logic [BLOCK_W-1:0] next_state,
  output logic [KEY_W-1:0]   next_key
);

  logic [BLOCK_W-1:0] mixed;
  logic [BLOCK_W-1:0] sboxed;
  logic [KEY_W-1:0]   rotated;

  assign mixed = state ^ keyreg[79:16];

  for (genvar n = 0; n < 16; n++) begin : g_sbox
    assign sboxed[4*n +: 4] = sbox4(mixed[4*n +: 4]);
  end

  assign next_state = p_layer(sboxed);

  // Rotate left by 61, substitute the top nibble, then fold in the round counter.
  assign rotated  = {keyreg[18:0], keyreg[79:19]};
  assign next_key = {sbox4(rotated[79:76]), rotated[75:20],
                     rotated[19:15] ^ round, rotated[14:0]};

endmodule

// File: rtl/present_ctrl.sv
// Iterative PRESENT-80 sequencer, one round per clock. Optional abort input under PRESENT_ABORT_EN.
module present_ctrl
  import present_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
`ifdef PRESENT_ABORT_EN
  input  logic               abort,
`endif
  input  logic [BLOCK_W-1:0] plaintext,
  input  logic [KEY_W-1:0]   keys,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [BLOCK_W-1:0] result,
  output logic [ROUND_W-1:0] round
);

  fsm_t               fsm;
  logic [BLOCK_W-1:0] state;
  logic [KEY_W-1:0]   keyreg;
  logic [BLOCK_W-1:0] next_state;
  logic [KEY_W-1:0]   next_key;
  logic               abort_req;

`ifdef PRESENT_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  present_round u_round (
    .state      (state),
    .keyreg     (keyreg),
    .round      (round),
    .next_state (next_state),
    .next_key   (next_key)
  );

  // The counter holds at ROUNDS through FINAL rather than rolling over to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm    <= IDLE;
      state  <= '0;
      keyreg <= '0;
      round  <= '0;
      result <= '0;
      done   <= 1'b0;
      ready  <= 1'b1;
      busy   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (fsm)
        IDLE: begin
          if (start) begin
            state  <= plaintext;
            keyreg <= keys;
            round  <= 5'd1;
            fsm    <= RUN;
            ready  <= 1'b0;
            busy   <= 1'b1;
          end
        end
        RUN: begin
          if (abort_req) begin
            round <= '0;
            fsm   <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state  <= next_state;
            keyreg <= next_key;
            if (round == ROUNDS) begin
              fsm <= FINAL;
            end else begin
              round <= round + 5'd1;
            end
          end
        end
        FINAL: begin
          result <= state ^ keyreg[79:16];
          done   <= 1'b1;
          round  <= '0;
          fsm    <= IDLE;
          ready  <= 1'b1;
          busy   <= 1'b0;
        end
        default: begin
          fsm   <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_present_ctrl.sv
// Bench for present_ctrl: known vectors plus random blocks against a behavioural PRESENT-80 model.
`timescale 1ns/1ps
module tb_present_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [63:0] plaintext;
  logic [79:0] keys;
  logic        ready;
  logic        busy;
  logic        done;
  logic [63:0] result;
  logic [4:0]  round;
`ifdef PRESENT_ABORT_EN
  logic        abort;
`endif

  int checks;
  int failures;
  logic [63:0] last_result;

  present_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
`ifdef PRESENT_ABORT_EN
    .abort     (abort),
`endif
    .plaintext (plaintext),
    .keys      (keys),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .round     (round)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Textbook PRESENT-80 encryption, written directly from the algorithm description.
  function automatic logic [63:0] model(input logic [63:0] pt, input logic [79:0] k);
    logic [3:0]  sb [16];
    logic [63:0] s;
    logic [63:0] t;
    logic [79:0] key;
    sb = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
           4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
    s = pt;
    key = k;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ key[79:16];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = sb[s[4*n +: 4]];
      t = '0;
      for (int i = 0; i < 64; i++) t[(i == 63) ? 63 : (i * 16) % 63] = s[i];
      s = t;
      key = (key << 61) | (key >> 19);
      key[79:76] = sb[key[79:76]];
      key[19:15] = key[19:15] ^ 5'(r);
    end
    return s ^ key[79:16];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pulses start for one cycle, then waits for done and checks latency and ciphertext.
  task automatic run_block(input logic [63:0] pt, input logic [79:0] k,
                           input logic [63:0] exp, input string tag);
    int n;
    start = 1'b1;
    plaintext = pt;
    keys = k;
    tick();
    start = 1'b0;
    plaintext = {$urandom, $urandom};
    keys = {16'($urandom), $urandom, $urandom};
    check({tag, "_busy"}, 64'(busy), 64'd1);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < 40);
    check({tag, "_latency"}, 64'(n), 64'd32);
    check({tag, "_result"}, result, exp);
    check({tag, "_ready"}, 64'(ready), 64'd1);
    tick();
    check({tag, "_done_width"}, 64'(done), 64'd0);
    last_result = exp;
  endtask

  initial begin
    int n;
    logic [63:0] pa, pb, rp;
    logic [79:0] ka, kb, rk;
    checks = 0;
    failures = 0;
    last_result = '0;
    rst = 1'b1;
    start = 1'b0;
    plaintext = '0;
    keys = '0;
`ifdef PRESENT_ABORT_EN
    abort = 1'b0;
`endif
    tick();
    tick();
    check("reset_ready", 64'(ready), 64'd1);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_result", result, 64'd0);
    check("reset_round", 64'(round), 64'd0);
    rst = 1'b0;
    tick();
    check("idle_no_start", 64'(ready), 64'd1);

    run_block(64'h0, 80'h0, 64'h5579C1387B228445, "vec_zero");
    run_block(64'hFFFF_FFFF_FFFF_FFFF, 80'hFFFF_FFFF_FFFF_FFFF_FFFF,
              64'h3333DCD3213210D2, "vec_ones");
    run_block(64'hFFFF_FFFF_FFFF_FFFF, 80'h0, 64'hA112FFC72F68417B, "vec_pt_ones");

    // Round counter walk with plaintext=0, keys=all ones.
    start = 1'b1;
    plaintext = 64'h0;
    keys = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
    tick();
    start = 1'b0;
    for (int r = 1; r <= 31; r++) begin
      check($sformatf("round_step_%0d", r), 64'(round), 64'(r));
      tick();
    end
    tick();
    check("walk_done", 64'(done), 64'd1);
    check("walk_result", result, 64'hE72C46C0F5945049);
    check("walk_round_idle", 64'(round), 64'd0);
    last_result = 64'hE72C46C0F5945049;
    tick();

    for (int i = 0; i < 5; i++) begin
      rp = {$urandom, $urandom};
      rk = {16'($urandom), $urandom, $urandom};
      run_block(rp, rk, model(rp, rk), $sformatf("rand%0d", i));
    end

    // start held high: accepted at E0 and E33 only, inputs changing mid-run.
    pa = {$urandom, $urandom};
    ka = {16'($urandom), $urandom, $urandom};
    start = 1'b1;
    plaintext = pa;
    keys = ka;
    tick();
    plaintext = ~pa;
    keys = ~ka;
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < 40);
    check("held_latency_a", 64'(n), 64'd32);
    check("held_result_a", result, model(pa, ka));
    pb = {$urandom, $urandom};
    kb = {16'($urandom), $urandom, $urandom};
    plaintext = pb;
    keys = kb;
    tick();
    check("held_accept_b", 64'(busy), 64'd1);
    check("held_done_low", 64'(done), 64'd0);
    plaintext = {$urandom, $urandom};
    n = 1;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    check("held_spacing", 64'(n), 64'd33);
    check("held_result_b", result, model(pb, kb));
    last_result = model(pb, kb);
    start = 1'b0;
    tick();
    check("held_done_width", 64'(done), 64'd0);

    // Asynchronous reset at round 15.
    start = 1'b1;
    plaintext = {$urandom, $urandom};
    keys = {16'($urandom), $urandom, $urandom};
    tick();
    start = 1'b0;
    repeat (14) tick();
    check("pre_rst_round", 64'(round), 64'd15);
    rst = 1'b1;
    #1;
    check("async_rst_ready", 64'(ready), 64'd1);
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_round", 64'(round), 64'd0);
    check("async_rst_result", result, 64'd0);
    tick();
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done) n++;
    end
    check("rst_no_done", 64'(n), 64'd0);
    run_block(64'h0, 80'hFFFF_FFFF_FFFF_FFFF_FFFF, 64'hE72C46C0F5945049, "post_rst");

`ifdef PRESENT_ABORT_EN
    start = 1'b1;
    plaintext = {$urandom, $urandom};
    keys = {16'($urandom), $urandom, $urandom};
    tick();
    start = 1'b0;
    repeat (9) tick();
    check("abort_at_round", 64'(round), 64'd10);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_ready", 64'(ready), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_round", 64'(round), 64'd0);
    check("abort_result_held", result, last_result);
    check("abort_no_done", 64'(done), 64'd0);

    // Abort while round 31 is being applied beats the move to FINAL.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (30) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_r31_ready", 64'(ready), 64'd1);
    tick();
    check("abort_r31_no_done", 64'(done), 64'd0);

    // Abort in FINAL is ignored.
    pa = {$urandom, $urandom};
    ka = {16'($urandom), $urandom, $urandom};
    start = 1'b1;
    plaintext = pa;
    keys = ka;
    tick();
    start = 1'b0;
    repeat (31) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_final_done", 64'(done), 64'd1);
    check("abort_final_result", result, model(pa, ka));
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
